// File: rtl/coinc_window_readout.sv
// coinc_window_readout
// Takes a snapshot of the free-running pair counters at the end of every
// programmable window and streams the per-pair deltas as one frame of NCOMB
// words over valid/ready. A window that closes while the previous frame is
// still streaming is discarded and counted in a saturating drop counter.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no frame pending, OutValid low, next closed window is accepted
//  SEND  | streaming buf[idx] to the consumer, one word per handshake
module coinc_window_readout #(
  parameter  int NCHAN = 4,
  parameter  int NBITS = 4,
  parameter  int NCOMB = NCHAN * (NCHAN - 1) / 2,
  parameter  int WINW  = 16,
  localparam int IDXW  = (NCOMB > 1) ? $clog2(NCOMB) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NBITS-1:0] Counts [NCOMB-1:0],
  input  logic             Enable,
  input  logic [WINW-1:0]  WinCycles,
  output logic [NBITS-1:0] OutData,
  output logic [IDXW-1:0]  OutIdx,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutLast,
  output logic             FrameDrop,
  output logic [7:0]       DropCount
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCOMB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WINW-1:0]  win_cnt_q, win_cnt_d;
  logic [WINW-1:0]  win_lim;
  logic             win_close;
  logic [NBITS-1:0] base_q [NCOMB];
  logic [NBITS-1:0] base_d [NCOMB];
  logic [NBITS-1:0] delta  [NCOMB];
  logic [NBITS-1:0] buf_q  [NCOMB];
  logic [NBITS-1:0] buf_d  [NCOMB];
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             handshake;
  logic             last_hs;
  logic             accept;
  logic [NBITS-1:0] out_data_q, out_data_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             drop_q, drop_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // A zero window length behaves as a one-cycle window.
  assign win_lim   = (WinCycles == '0) ? '0 : WinCycles - WINW'(1);
  assign win_close = Enable && (win_cnt_q == win_lim);

  // Handshakes are judged on the registered outputs the consumer sees.
  assign handshake = valid_q && OutReady;
  assign last_hs   = handshake && last_q;
  assign accept    = win_close && ((state_q == IDLE) || last_hs);

  // Window counter: held at zero while disabled, restarts on every close.
  always_comb begin
    win_cnt_d = win_cnt_q + WINW'(1);
    if (!Enable || win_close) begin
      win_cnt_d = '0;
    end
  end

  // Deltas are plain NBITS-wide differences so counter wrap falls out naturally;
  // the base follows the counters while disabled and re-arms on every close.
  always_comb begin
    for (int k = 0; k < NCOMB; k++) begin
      delta[k]  = Counts[k] - base_q[k];
      base_d[k] = (!Enable || win_close) ? Counts[k] : base_q[k];
    end
  end

  // Frame FSM: accept or drop closed windows, advance through the frame.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (accept) begin
      buf_d   = delta;
      state_d = SEND;
      idx_d   = '0;
    end else begin
      if (win_close) begin
        drop_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      if (handshake) begin
        if (last_q) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
    end

    valid_d    = (state_d == SEND);
    out_data_d = valid_d ? buf_d[idx_d] : '0;
    out_idx_d  = valid_d ? idx_d : '0;
    last_d     = valid_d && (idx_d == LAST_IDX);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Window counter, base snapshot and frame buffer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      win_cnt_q <= '0;
      for (int k = 0; k < NCOMB; k++) begin
        base_q[k] <= '0;
        buf_q[k]  <= '0;
      end
    end else begin
      win_cnt_q <= win_cnt_d;
      for (int k = 0; k < NCOMB; k++) begin
        base_q[k] <= base_d[k];
        buf_q[k]  <= buf_d[k];
      end
    end
  end

  // Registered stream and drop outputs; no path from OutReady to the outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data_q <= '0;
      out_idx_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign OutData   = out_data_q;
  assign OutIdx    = out_idx_q;
  assign OutValid  = valid_q;
  assign OutLast   = last_q;
  assign FrameDrop = drop_q;
  assign DropCount = drop_cnt_q;

endmodule
